load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/load_store_unit_align.sv | 30 +++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM state
// encoding, the default data width and the byte-enable/legality helpers.
package load_store_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Misaligned halfword/word offsets collapse onto the aligned lanes.
    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: byte_enables = 4'b0001 << off;
            F3_H, F3_HU: byte_enables = off[1] ? 4'b1100 : 4'b0011;
            F3_W:        byte_enables = 4'b1111;
            default:     byte_enables = 4'b0000;
        endcase
    endfunction

    // Unsigned widths exist only for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic store);
        case (f3)
            F3_B, F3_H, F3_W: f3_illegal = 1'b0;
            F3_BU, F3_HU:     f3_illegal = store;
            default:          f3_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// load_align: picks the addressed byte/halfword lane out of a read word and
// sign- or zero-extends it to XLEN according to funct3.
module load_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] result_o
);

    logic signed [7:0]  byte_lane;
    logic signed [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[{offset_i, 3'b000} +: 8];
        half_lane = rdata_i[{offset_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    result_o = XLEN'(byte_lane);
            F3_H:    result_o = XLEN'(half_lane);
            F3_BU:   result_o = {{(XLEN-8){1'b0}}, byte_lane};
            F3_HU:   result_o = {{(XLEN-16){1'b0}}, half_lane};
            F3_W:    result_o = rdata_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/REQ/WAIT/RESP handshake with a single-word memory port,
// WAIT timeout, and optional misalignment trap (macro LSU_MISALIGN_TRAP_EN).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] write_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] load_result,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    logic [1:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;
    logic            store_q, store_d;
    logic [XLEN-1:0] load_result_q, load_result_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic            mem_we_q, mem_we_d;

    logic            misaligned;
    logic [XLEN-1:0] store_lanes;
    logic [XLEN-1:0] aligned_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && address[0])
                      || ((funct3 == F3_W) && (address[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        case (funct3[1:0])
            2'b00:   store_lanes = {(XLEN/8){write_data[7:0]}};
            2'b01:   store_lanes = {(XLEN/16){write_data[15:0]}};
            default: store_lanes = write_data;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3_i (funct3_q),
        .offset_i (off_q),
        .rdata_i  (mem_rdata),
        .result_o (aligned_data)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        funct3_d      = funct3_q;
        off_d         = off_q;
        store_d       = store_q;
        load_result_d = load_result_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        mem_we_d      = mem_we_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Illegal requests finish next cycle without touching memory.
                    if (f3_illegal(funct3, is_store) || misaligned) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        err_d       = 1'b0;
                        funct3_d    = funct3;
                        off_d       = address[1:0];
                        store_d     = is_store;
                        mem_addr_d  = {address[XLEN-1:2], 2'b00};
                        mem_wdata_d = store_lanes;
                        mem_be_d    = byte_enables(funct3, address[1:0]);
                        mem_we_d    = is_store;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    state_d  = S_RESP;
                    mem_be_d = 4'b0000;
                    mem_we_d = 1'b0;
                    if (!store_q) begin
                        load_result_d = aligned_data;
                    end
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = S_RESP;
                    err_d    = 1'b1;
                    mem_be_d = 4'b0000;
                    mem_we_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            funct3_q      <= '0;
            off_q         <= '0;
            store_q       <= 1'b0;
            load_result_q <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
            store_q       <= store_d;
            load_result_q <= load_result_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            mem_we_q      <= mem_we_d;
        end
    end

    // busy covers REQ/WAIT only, so the PC stall releases in the done cycle.
    assign busy        = (state_q == S_REQ) || (state_q == S_WAIT);
    assign mem_req     = busy;
    assign done        = (state_q == S_RESP);
    assign err         = done && err_q;
    assign load_result = load_result_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES = 4): vector table plus
// hand sequences for reset, ignored starts and reset during an access.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] load_result, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .address(address), .write_data(write_data), .busy(busy), .done(done),
        .load_result(load_result), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;      // WAIT cycles before mem_ready; large = never
        bit          exp_mem;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        bit          chk_wd;
        logic [31:0] exp_wd;
        bit          exp_err;
        int          exp_lat;
        bit          chk_res;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit st, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                                logic [31:0] rd, int dly, bit exp_mem, logic [31:0] exp_addr,
                                logic [3:0] exp_be, bit chk_wd, logic [31:0] exp_wd,
                                bit exp_err, int exp_lat, bit chk_res, logic [31:0] exp_res);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.dly = dly;
        v.exp_mem = exp_mem; v.exp_addr = exp_addr; v.exp_be = exp_be;
        v.chk_wd = chk_wd; v.exp_wd = exp_wd; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.chk_res = chk_res; v.exp_res = exp_res;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int reqcnt;
        bit done_seen;
        bit stable;
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        string nm;
        nm = $sformatf("v%0d", idx);
        start = 1'b1; is_store = v.st; funct3 = v.f3; address = v.addr; write_data = v.wd;
        mem_rdata = v.rd;
        tick();
        // Scramble request inputs: the access in flight must not notice.
        start = 1'b0; is_store = ~v.st; funct3 = 3'b111; address = ~v.addr; write_data = ~v.wd;
        cyc = 1; reqcnt = 0; done_seen = 1'b0; stable = 1'b1;
        a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
        while (cyc <= 40 && !done_seen) begin
            mem_ready = 1'b0;
            if (done) begin
                done_seen = 1'b1;
                chk({nm, " latency"}, 32'(cyc), 32'(v.exp_lat));
                chk({nm, " err"}, 32'(err), 32'(v.exp_err));
                chk({nm, " mem_req at done"}, 32'(mem_req), 32'd0);
                if (v.chk_res) chk({nm, " load_result"}, load_result, v.exp_res);
            end else if (mem_req) begin
                reqcnt++;
                if (reqcnt == 1) begin
                    a0 = mem_addr; w0 = mem_wdata; b0 = mem_be; we0 = mem_we;
                    chk({nm, " mem_addr"}, mem_addr, v.exp_addr);
                    chk({nm, " mem_be"}, 32'(mem_be), 32'(v.exp_be));
                    chk({nm, " mem_we"}, 32'(mem_we), 32'(v.st));
                    if (v.chk_wd) chk({nm, " mem_wdata"}, mem_wdata, v.exp_wd);
                end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_be !== b0 || mem_we !== we0) begin
                    stable = 1'b0;
                end
                if (reqcnt == 2 + v.dly) mem_ready = 1'b1;
            end
            if (!done_seen) begin
                tick();
                cyc++;
            end
        end
        mem_ready = 1'b0;
        chk({nm, " done seen"}, 32'(done_seen), 32'd1);
        chk({nm, " mem access"}, 32'(reqcnt != 0), 32'(v.exp_mem));
        if (v.exp_mem) chk({nm, " request stable"}, 32'(stable), 32'd1);
        tick();
    endtask

    initial begin
        int dn;
        // st  f3      addr    wd            rd            dly mem eaddr  ebe  cwd ewd           err lat cres eres
        vecs.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 32'h10, 4'b1111, 1, 32'hDEADBEEF, 0, 3, 1, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h13, 32'h0,        32'h80FF0000, 0, 1, 32'h10, 4'b1000, 0, 32'h0,        0, 3, 1, 32'hFFFFFF80));
        vecs.push_back(mk(0, 3'b100, 32'h13, 32'h0,        32'h80FF0000, 0, 1, 32'h10, 4'b1000, 0, 32'h0,        0, 3, 1, 32'h00000080));
        vecs.push_back(mk(1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0,        0, 1, 32'h20, 4'b1100, 1, 32'hABCDABCD, 0, 3, 1, 32'h00000080));
        vecs.push_back(mk(0, 3'b001, 32'h22, 32'h0,        32'h7FFF0000, 0, 1, 32'h20, 4'b1100, 0, 32'h0,        0, 3, 1, 32'h00007FFF));
        vecs.push_back(mk(0, 3'b101, 32'h20, 32'h0,        32'h12348001, 2, 1, 32'h20, 4'b0011, 0, 32'h0,        0, 5, 1, 32'h00008001));
        vecs.push_back(mk(0, 3'b001, 32'h20, 32'h0,        32'h12348001, 0, 1, 32'h20, 4'b0011, 0, 32'h0,        0, 3, 1, 32'hFFFF8001));
        vecs.push_back(mk(0, 3'b010, 32'h44, 32'h0,        32'hCAFEF00D, 1, 1, 32'h44, 4'b1111, 0, 32'h0,        0, 4, 1, 32'hCAFEF00D));
        vecs.push_back(mk(1, 3'b000, 32'h31, 32'h000000A5, 32'h0,        0, 1, 32'h30, 4'b0010, 1, 32'hA5A5A5A5, 0, 3, 0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h31, 32'h0,        32'h00007F00, 0, 1, 32'h30, 4'b0010, 0, 32'h0,        0, 3, 1, 32'h0000007F));
        // Timeout: four WAIT cycles with no ready, previous load result kept.
        vecs.push_back(mk(0, 3'b010, 32'h50, 32'h0,        32'hFFFFFFFF, 99, 1, 32'h50, 4'b1111, 0, 32'h0,       1, 6, 1, 32'h0000007F));
        vecs.push_back(mk(0, 3'b011, 32'h50, 32'h0,        32'h0,        0, 0, 32'h0,  4'b0000, 0, 32'h0,        1, 1, 1, 32'h0000007F));
        vecs.push_back(mk(1, 3'b100, 32'h50, 32'h55,       32'h0,        0, 0, 32'h0,  4'b0000, 0, 32'h0,        1, 1, 1, 32'h0000007F));
        vecs.push_back(mk(0, 3'b110, 32'h50, 32'h0,        32'h0,        0, 0, 32'h0,  4'b0000, 0, 32'h0,        1, 1, 1, 32'h0000007F));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 3'b010, 32'h06, 32'h0,        32'h11223344, 0, 0, 32'h0,  4'b0000, 0, 32'h0,        1, 1, 1, 32'h0000007F));
        vecs.push_back(mk(0, 3'b101, 32'h23, 32'h0,        32'hBEEF0000, 0, 0, 32'h0,  4'b0000, 0, 32'h0,        1, 1, 1, 32'h0000007F));
`else
        vecs.push_back(mk(0, 3'b010, 32'h06, 32'h0,        32'h11223344, 0, 1, 32'h04, 4'b1111, 0, 32'h0,        0, 3, 1, 32'h11223344));
        vecs.push_back(mk(0, 3'b101, 32'h23, 32'h0,        32'hBEEF0000, 0, 1, 32'h20, 4'b1100, 0, 32'h0,        0, 3, 1, 32'h0000BEEF));
`endif

        // Reset state
        rst = 1'b0;
        tick(); tick(); tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_be", 32'(mem_be), 32'd0);
        chk("reset load_result", load_result, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Start during WAIT is dropped; start during RESP is dropped.
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; address = 32'h40;
        mem_rdata = 32'h0BADF00D;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; funct3 = 3'b000; address = 32'h80;
        chk("seqA busy in WAIT", 32'(busy), 32'd1);
        tick();
        start = 1'b0;
        chk("seqA mem_addr kept", mem_addr, 32'h40);
        chk("seqA mem_be kept", 32'(mem_be), 32'hF);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("seqA done", 32'(done), 32'd1);
        chk("seqA err", 32'(err), 32'd0);
        chk("seqA load_result", load_result, 32'h0BADF00D);
        start = 1'b1; address = 32'hC0;
        tick();
        start = 1'b0;
        chk("seqA RESP start busy", 32'(busy), 32'd0);
        chk("seqA RESP start mem_req", 32'(mem_req), 32'd0);
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            if (done || mem_req) dn++;
            tick();
        end
        chk("seqA no extra activity", 32'(dn), 32'd0);

        // Reset in the middle of an access abandons it silently.
        start = 1'b1; is_store = 1'b0; funct3 = 3'b001; address = 32'h60;
        tick();
        start = 1'b0;
        tick();
        chk("seqB mem_req in WAIT", 32'(mem_req), 32'd1);
        rst = 1'b0;
        tick();
        chk("seqB mem_req after reset", 32'(mem_req), 32'd0);
        chk("seqB busy after reset", 32'(busy), 32'd0);
        chk("seqB done after reset", 32'(done), 32'd0);
        chk("seqB load_result cleared", load_result, 32'd0);
        rst = 1'b1;
        mem_ready = 1'b1;
        dn = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) dn++;
            tick();
        end
        mem_ready = 1'b0;
        chk("seqB no done after reset", 32'(dn), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
